// File: rtl/user_command_sender_if.sv
// Command, write-payload and response handshake between a host and user_command_sender.
// The master drives commands and payload; the slave (the sender) returns status and data.
interface user_command_sender_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [23:0] cmd_len;
  logic [31:0] cmd_addr;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_addr, wr_data, wr_valid,
    input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done, error
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_addr, wr_data, wr_valid,
    output cmd_ready, wr_ready, rd_data, rd_valid, busy, done, error
  );
endinterface

// File: rtl/user_command_sender.sv
// Initiator for the "!"-framed serial memory protocol: serializes one command onto a
// byte-wide UART, streams write payload, then collects and forwards the response.
module user_command_sender #(
  parameter int TIMEOUT     = 1000000,
  parameter int VERSION_LEN = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  user_command_sender_if.slave cmd,
  output logic [7:0]           uart_txd,
  output logic                 uart_txd_strobe,
  input  logic                 uart_txd_ready,
  input  logic [7:0]           uart_rxd,
  input  logic                 uart_rxd_strobe
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_HDR   = 4'd1;
  localparam logic [3:0] S_OP    = 4'd2;
  localparam logic [3:0] S_L2    = 4'd3;
  localparam logic [3:0] S_L1    = 4'd4;
  localparam logic [3:0] S_L0    = 4'd5;
  localparam logic [3:0] S_A3    = 4'd6;
  localparam logic [3:0] S_A2    = 4'd7;
  localparam logic [3:0] S_A1    = 4'd8;
  localparam logic [3:0] S_A0    = 4'd9;
  localparam logic [3:0] S_WDATA = 4'd10;
  localparam logic [3:0] S_WACK  = 4'd11;
  localparam logic [3:0] S_RESP  = 4'd12;

  localparam logic [1:0] OP_READ    = 2'd0;
  localparam logic [1:0] OP_WRITE   = 2'd1;
  localparam logic [1:0] OP_VERSION = 2'd2;
  localparam logic [1:0] OP_INVALID = 2'd3;

  localparam int            TW           = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_ONE    = TW'(1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  logic [3:0]    state_reg;
  logic [1:0]    op_reg;
  logic [23:0]   len_reg;
  logic [31:0]   addr_reg;
  logic [23:0]   remaining_reg;
  logic [TW-1:0] timer_reg;
  logic [7:0]    txd_reg;
  logic          txd_strobe_reg;
  logic          wr_ready_reg;
  logic [7:0]    rd_data_reg;
  logic          rd_valid_reg;
  logic          done_reg;
  logic          error_reg;

  logic [7:0] hdr_byte;
  logic       can_tx;
  logic       timed_out;

  // A byte may only leave when the UART is ready and no strobe was issued last cycle.
  assign can_tx    = uart_txd_ready && !txd_strobe_reg;
  // timer_reg counts cycles since the last byte, so the next count reaching TIMEOUT expires.
  assign timed_out = (timer_reg == TIMEOUT_LAST);

  assign cmd.cmd_ready   = (state_reg == S_IDLE);
  assign cmd.busy        = (state_reg != S_IDLE);
  assign cmd.wr_ready    = wr_ready_reg;
  assign cmd.rd_data     = rd_data_reg;
  assign cmd.rd_valid    = rd_valid_reg;
  assign cmd.done        = done_reg;
  assign cmd.error       = error_reg;
  assign uart_txd        = txd_reg;
  assign uart_txd_strobe = txd_strobe_reg;

  always_comb begin
    hdr_byte = 8'h00;
    case (state_reg)
      S_HDR: hdr_byte = 8'h21;
      S_OP: begin
        case (op_reg)
          OP_READ:    hdr_byte = 8'h52;
          OP_WRITE:   hdr_byte = 8'h57;
          OP_VERSION: hdr_byte = 8'h56;
          default:    hdr_byte = 8'hFF;
        endcase
      end
      S_L2:    hdr_byte = len_reg[23:16];
      S_L1:    hdr_byte = len_reg[15:8];
      S_L0:    hdr_byte = len_reg[7:0];
      S_A3:    hdr_byte = addr_reg[31:24];
      S_A2:    hdr_byte = addr_reg[23:16];
      S_A1:    hdr_byte = addr_reg[15:8];
      S_A0:    hdr_byte = addr_reg[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      op_reg         <= 2'd0;
      len_reg        <= 24'd0;
      addr_reg       <= 32'd0;
      remaining_reg  <= 24'd0;
      timer_reg      <= '0;
      txd_reg        <= 8'd0;
      txd_strobe_reg <= 1'b0;
      wr_ready_reg   <= 1'b0;
      rd_data_reg    <= 8'd0;
      rd_valid_reg   <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      txd_strobe_reg <= 1'b0;
      wr_ready_reg   <= 1'b0;
      rd_valid_reg   <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            op_reg    <= cmd.cmd_op;
            len_reg   <= cmd.cmd_len;
            addr_reg  <= cmd.cmd_addr;
            state_reg <= S_HDR;
          end
        end

        S_HDR, S_L2, S_L1, S_L0, S_A3, S_A2, S_A1: begin
          if (can_tx) begin
            txd_reg        <= hdr_byte;
            txd_strobe_reg <= 1'b1;
            state_reg      <= state_reg + 4'd1;
          end
        end

        // Version and invalid ops carry no length/address fields.
        S_OP: begin
          if (can_tx) begin
            txd_reg        <= hdr_byte;
            txd_strobe_reg <= 1'b1;
            remaining_reg  <= 24'(VERSION_LEN);
            timer_reg      <= TIMER_ONE;
            if (op_reg == OP_VERSION || op_reg == OP_INVALID) state_reg <= S_RESP;
            else                                               state_reg <= S_L2;
          end
        end

        S_A0: begin
          if (can_tx) begin
            txd_reg        <= hdr_byte;
            txd_strobe_reg <= 1'b1;
            remaining_reg  <= len_reg;
            timer_reg      <= TIMER_ONE;
            state_reg      <= (op_reg == OP_WRITE) ? S_WDATA : S_RESP;
          end
        end

        S_WDATA: begin
          if (remaining_reg == 24'd0) begin
            timer_reg <= TIMER_ONE;
            state_reg <= S_WACK;
          end else if (cmd.wr_valid && can_tx) begin
            txd_reg        <= cmd.wr_data;
            txd_strobe_reg <= 1'b1;
            wr_ready_reg   <= 1'b1;
            remaining_reg  <= remaining_reg - 24'd1;
            timer_reg      <= TIMER_ONE;
          end else if (timed_out) begin
            error_reg <= 1'b1;
            state_reg <= S_IDLE;
          end else begin
            timer_reg <= timer_reg + TIMER_ONE;
          end
        end

        // The acknowledge byte is consumed here and never forwarded.
        S_WACK: begin
          if (uart_rxd_strobe) begin
            if (uart_rxd == 8'h77) done_reg  <= 1'b1;
            else                   error_reg <= 1'b1;
            state_reg <= S_IDLE;
          end else if (timed_out) begin
            error_reg <= 1'b1;
            state_reg <= S_IDLE;
          end else begin
            timer_reg <= timer_reg + TIMER_ONE;
          end
        end

        S_RESP: begin
          if (op_reg == OP_INVALID) begin
            if (uart_rxd_strobe) begin
              rd_data_reg  <= uart_rxd;
              rd_valid_reg <= 1'b1;
              if (uart_rxd == 8'h3F) done_reg  <= 1'b1;
              else                   error_reg <= 1'b1;
              state_reg <= S_IDLE;
            end else if (timed_out) begin
              error_reg <= 1'b1;
              state_reg <= S_IDLE;
            end else begin
              timer_reg <= timer_reg + TIMER_ONE;
            end
          end else if (remaining_reg == 24'd0) begin
            done_reg  <= 1'b1;
            state_reg <= S_IDLE;
          end else if (uart_rxd_strobe) begin
            rd_data_reg   <= uart_rxd;
            rd_valid_reg  <= 1'b1;
            remaining_reg <= remaining_reg - 24'd1;
            timer_reg     <= TIMER_ONE;
          end else if (timed_out) begin
            error_reg <= 1'b1;
            state_reg <= S_IDLE;
          end else begin
            timer_reg <= timer_reg + TIMER_ONE;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_user_command_sender.sv
// Directed-vector bench for user_command_sender: version, read, write, invalid op,
// zero-length read, response timeout and reset abort.
module tb_user_command_sender;
  localparam int TIMEOUT = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] uart_txd;
  logic       uart_txd_strobe;
  logic       uart_txd_ready = 1'b1;
  logic [7:0] uart_rxd = 8'h00;
  logic       uart_rxd_strobe = 1'b0;

  always #5 clk = ~clk;

  user_command_sender_if u_if ();

  user_command_sender #(.TIMEOUT(TIMEOUT), .VERSION_LEN(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd             (u_if.slave),
    .uart_txd        (uart_txd),
    .uart_txd_strobe (uart_txd_strobe),
    .uart_txd_ready  (uart_txd_ready),
    .uart_rxd        (uart_rxd),
    .uart_rxd_strobe (uart_rxd_strobe)
  );

  int         vec_count = 0;
  int         miscompares = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] exp_q[$];
  int         done_cnt = 0;
  int         error_cnt = 0;
  int         b2b_cnt = 0;
  int         cyc = 0;
  logic       prev_strobe = 1'b0;
  logic [7:0] payload[4];
  int         pay_n = 0;
  int         pay_idx = 0;
  bit         toggle_ready = 1'b0;
  int         d_base = 0;
  int         e_base = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // One clock: sample outputs just after the edge, then update inputs for the next cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (uart_txd_strobe === 1'b1) begin
      tx_q.push_back(uart_txd);
      if (prev_strobe) b2b_cnt++;
    end
    prev_strobe = (uart_txd_strobe === 1'b1);
    if (u_if.rd_valid === 1'b1) rd_q.push_back(u_if.rd_data);
    if (u_if.done === 1'b1) done_cnt++;
    if (u_if.error === 1'b1) error_cnt++;
    if (u_if.wr_ready === 1'b1) pay_idx++;
    u_if.wr_valid = (pay_idx < pay_n);
    u_if.wr_data  = (pay_idx < 4) ? payload[pay_idx] : 8'h00;
    if (toggle_ready) uart_txd_ready = ~uart_txd_ready;
    uart_rxd_strobe = 1'b0;
  endtask

  task automatic start_cmd(input logic [1:0] op, input logic [23:0] len, input logic [31:0] addr);
    check_value("cmd_ready_idle", {31'd0, u_if.cmd_ready}, 32'd1);
    d_base         = done_cnt;
    e_base         = error_cnt;
    u_if.cmd_valid = 1'b1;
    u_if.cmd_op    = op;
    u_if.cmd_len   = len;
    u_if.cmd_addr  = addr;
    tick();
    u_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int k = 0;
    while (tx_q.size() < n && k < 400) begin
      tick();
      k++;
    end
    check_value("tx_count", tx_q.size(), n);
  endtask

  task automatic check_tx_seq(input string tag, input int base);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < tx_q.size()) check_value(tag, {24'd0, tx_q[base + i]}, {24'd0, exp_q[i]});
      else                        check_value(tag, 32'hDEAD_0000, {24'd0, exp_q[i]});
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    uart_rxd        = b;
    uart_rxd_strobe = 1'b1;
    tick();
  endtask

  task automatic wait_end(input int exp_done, input int exp_err);
    int k = 0;
    while (done_cnt == d_base && error_cnt == e_base && k < 300) begin
      tick();
      k++;
    end
    check_value("done_pulses", done_cnt - d_base, exp_done);
    check_value("error_pulses", error_cnt - e_base, exp_err);
    check_value("cmd_ready_after", {31'd0, u_if.cmd_ready}, 32'd1);
  endtask

  initial begin
    int base;
    int rbase;
    int c0;
    u_if.cmd_valid = 1'b0;
    u_if.cmd_op    = 2'd0;
    u_if.cmd_len   = 24'd0;
    u_if.cmd_addr  = 32'd0;
    u_if.wr_data   = 8'h00;
    u_if.wr_valid  = 1'b0;
    repeat (3) tick();
    check_value("rst_txd", {24'd0, uart_txd}, 32'd0);
    check_value("rst_strobes", {27'd0, uart_txd_strobe, u_if.wr_ready, u_if.rd_valid,
                                u_if.done, u_if.error}, 32'd0);
    check_value("rst_busy", {31'd0, u_if.busy}, 32'd0);
    reset = 1'b0;
    tick();

    // Version: "!V", eight '1' bytes back, then done
    base = tx_q.size(); rbase = rd_q.size();
    start_cmd(2'd2, 24'd0, 32'd0);
    wait_tx(base + 2);
    exp_q = '{8'h21, 8'h56};
    check_tx_seq("ver_tx", base);
    repeat (8) begin send_rx(8'h31); tick(); end
    wait_end(1, 0);
    check_value("ver_rd_count", rd_q.size() - rbase, 8);
    for (int i = rbase; i < rd_q.size(); i++) check_value("ver_rd_byte", {24'd0, rd_q[i]}, 32'h31);
    check_value("ver_busy_after", {31'd0, u_if.busy}, 32'd0);

    // Read of 3 bytes at 0x00012345
    base = tx_q.size(); rbase = rd_q.size();
    start_cmd(2'd0, 24'd3, 32'h0001_2345);
    wait_tx(base + 9);
    exp_q = '{8'h21, 8'h52, 8'h00, 8'h00, 8'h03, 8'h00, 8'h01, 8'h23, 8'h45};
    check_tx_seq("rd_tx", base);
    send_rx(8'hAA); tick(); send_rx(8'hBB); tick(); send_rx(8'hCC); tick();
    wait_end(1, 0);
    check_value("rd_count", rd_q.size() - rbase, 3);
    exp_q = '{8'hAA, 8'hBB, 8'hCC};
    for (int i = 0; i < 3; i++)
      if (rbase + i < rd_q.size()) check_value("rd_byte", {24'd0, rd_q[rbase + i]}, {24'd0, exp_q[i]});

    // Write of 2 bytes at 0x10 with a toggling transmitter, acked with 'w'
    base = tx_q.size(); rbase = rd_q.size(); b2b_cnt = 0;
    payload[0] = 8'h5A; payload[1] = 8'hA5; pay_idx = 0; pay_n = 2;
    toggle_ready = 1'b1;
    start_cmd(2'd1, 24'd2, 32'h0000_0010);
    wait_tx(base + 11);
    toggle_ready = 1'b0; uart_txd_ready = 1'b1;
    exp_q = '{8'h21, 8'h57, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h10, 8'h5A, 8'hA5};
    check_tx_seq("wr_tx", base);
    check_value("wr_back_to_back", b2b_cnt, 0);
    check_value("wr_consumed", pay_idx, 2);
    repeat (3) tick();
    send_rx(8'h77);
    wait_end(1, 0);
    pay_n = 0;

    // Same write, rejected with 'x': error, byte not forwarded
    base = tx_q.size();
    pay_idx = 0; pay_n = 2;
    start_cmd(2'd1, 24'd2, 32'h0000_0010);
    wait_tx(base + 11);
    repeat (3) tick();
    send_rx(8'h78);
    wait_end(0, 1);
    check_value("wr_nack_no_rd", rd_q.size() - rbase, 0);
    pay_n = 0;

    // Invalid op: "!" 0xFF, expects '?'
    base = tx_q.size();
    start_cmd(2'd3, 24'd0, 32'd0);
    wait_tx(base + 2);
    exp_q = '{8'h21, 8'hFF};
    check_tx_seq("inv_tx", base);
    send_rx(8'h3F);
    wait_end(1, 0);

    // Zero-length read: done one cycle after A0, nothing forwarded
    base = tx_q.size(); rbase = rd_q.size();
    start_cmd(2'd0, 24'd0, 32'hDEAD_BEEF);
    wait_tx(base + 9);
    c0 = cyc;
    exp_q = '{8'h21, 8'h52, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    check_tx_seq("zr_tx", base);
    wait_end(1, 0);
    check_value("zr_done_latency", cyc - c0, 1);
    check_value("zr_no_rd", rd_q.size() - rbase, 0);

    // Timeout: read of 4, only 2 bytes arrive
    base = tx_q.size(); rbase = rd_q.size();
    start_cmd(2'd0, 24'd4, 32'd0);
    wait_tx(base + 9);
    tick();
    send_rx(8'h11); tick();
    send_rx(8'h22);
    c0 = cyc - 1;  // cycle in which the last byte was presented
    wait_end(0, 1);
    check_value("to_cycles", cyc - c0, TIMEOUT);
    check_value("to_rd_count", rd_q.size() - rbase, 2);
    check_value("to_busy", {31'd0, u_if.busy}, 32'd0);

    // Reset during WDATA after the first of four payload bytes
    base = tx_q.size();
    payload[0] = 8'h01; pay_idx = 0; pay_n = 1;
    start_cmd(2'd1, 24'd4, 32'h0000_0020);
    wait_tx(base + 10);
    check_value("rst_wd_consumed", pay_idx, 1);
    d_base = done_cnt; e_base = error_cnt;
    reset = 1'b1;
    tick();
    check_value("rstw_txd", {24'd0, uart_txd}, 32'd0);
    check_value("rstw_strobes", {27'd0, uart_txd_strobe, u_if.wr_ready, u_if.rd_valid,
                                 u_if.done, u_if.error}, 32'd0);
    check_value("rstw_busy", {31'd0, u_if.busy}, 32'd0);
    check_value("rstw_cmd_ready", {31'd0, u_if.cmd_ready}, 32'd1);
    reset = 1'b0; pay_n = 0;
    repeat (5) tick();
    check_value("rstw_no_done", done_cnt - d_base, 0);
    check_value("rstw_no_error", error_cnt - e_base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/user_command_sender.md
Name: user_command_sender

Overview:
Hardware initiator for the "!"-framed serial memory protocol. It accepts one command at a time (read, write or version) on a valid/ready port and serializes it onto a byte-wide UART transmit interface. It streams write payload bytes out, then collects response bytes from the UART receive interface and forwards them. Used for loopback self-test and for board-to-board control of a peer spispy unit.

Parameters:
TIMEOUT, 1000000, idle cycles with no received byte while a response is expected before an error is flagged.
VERSION_LEN, 8, number of response bytes expected for a version command.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high in IDLE only; command accepted when cmd_valid && cmd_ready
cmd_op  in  2  0=read "R", 1=write "W", 2=version "V", 3=invalid (sent as 0xFF)
cmd_len  in  24  byte count, big-endian on the wire
cmd_addr  in  32  byte address, big-endian on the wire
wr_data  in  8  write payload byte
wr_valid  in  1  payload byte present
wr_ready  out  1  one-cycle strobe: payload byte consumed this cycle
rd_data  out  8  received response byte
rd_valid  out  1  one-cycle strobe qualifying rd_data
uart_txd  out  8  byte to transmit
uart_txd_strobe  out  1  one-cycle transmit strobe
uart_txd_ready  in  1  transmitter can take a byte
uart_rxd  in  8  received byte
uart_rxd_strobe  in  1  received-byte strobe
busy  out  1  high whenever the block is not in IDLE
done  out  1  one-cycle strobe: command completed successfully
error  out  1  one-cycle strobe: command aborted

Behaviour:
- Reset: state IDLE; uart_txd=0; all strobes (uart_txd_strobe, wr_ready, rd_valid, done, error) = 0; busy=0; counters cleared. Reset has priority and aborts any operation immediately; no done or error is issued.
- Accept: in IDLE with cmd_valid, latch op, len and addr; next state HDR. cmd_ready is combinational (state==IDLE).
- Transmit rule: a byte is sent by asserting uart_txd_strobe for exactly one cycle with uart_txd, only in a cycle where uart_txd_ready=1 and uart_txd_strobe was 0 in the previous cycle. This gives at most one byte every 2 cycles.
- Transmit sequence:
  - HDR sends "!" (0x21).
  - OP sends the opcode byte.
  - Version skips length and address and goes to RESP.
  - Read and write continue L2, L1, L0, then A3, A2, A1, A0, sending len[23:16] through len[7:0] and addr[31:24] through addr[7:0].
  - Invalid op goes from OP to RESP and expects "?".
- After A0:
  - Read goes to RESP with remaining=len.
  - Write goes to WDATA with remaining=len.
- WDATA: when wr_valid and the transmit rule allows, send wr_data, pulse wr_ready, decrement remaining. When remaining reaches 0 (including len=0 on entry), go to WACK.
- RESP:
  - Every uart_rxd_strobe byte is output on rd_data with a rd_valid pulse in the following cycle, and remaining decrements.
  - Remaining is VERSION_LEN for version, len for read.
  - At remaining=0, pulse done and return to IDLE. Read with len=0 finishes immediately after A0.
  - Invalid op: a received "?" gives done. Any other byte gives error.
- WACK: received "w" (0x77) gives done and IDLE. Any other byte gives error and IDLE; that byte is not forwarded.
- Receive bytes arriving in IDLE or during the transmit states are discarded.
- Timeout: in RESP, WACK and WDATA, a counter is cleared on every rx or tx byte and on state entry. When it reaches TIMEOUT, pulse error and return to IDLE.
- done and error are never asserted in the same cycle. Remaining is 24-bit and never decremented below 0.

Test Plan:
- Version: cmd_op=2 -> tx "!","V"; feed 8 bytes of "1" -> 8 rd_valid pulses with 0x31, then done; cmd_ready returns high the next cycle.
- Read: op=0, len=3, addr=0x00012345 -> tx 21 52 00 00 03 00 01 23 45; feed AA BB CC -> rd_data AA, BB, CC, then done.
- Write: op=1, len=2, addr=0x10, payload 5A A5, uart_txd_ready toggling -> tx 21 57 00 00 02 00 00 00 10 5A A5 with no strobes in back-to-back cycles; rx "w" -> done. Rx "x" instead -> error.
- Zero-length read: len=0 -> 9 header bytes, done 1 cycle after A0, no rd_valid.
- Timeout: TIMEOUT=50, read len=4, feed only 2 bytes -> error exactly 50 cycles after the last rx byte, state IDLE.
- Reset during WDATA after 1 of 4 bytes -> all outputs 0 next cycle, cmd_ready=1, no done or error.
